// File: rtl/rr_grant_scheduler_pkg.sv
// Shared constants for the round-robin grant scheduler: default sizing and
// FSM state encoding.
package rr_grant_scheduler_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_IDW      = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

endpackage

// File: rtl/rr_grant_scheduler_prio_encoder.sv
// Rotating priority encoder: finds the first set request scanning upward from
// ptr and wrapping, returning its absolute index.
module rr_prio_encoder #(
    parameter int N   = 8,
    parameter int IDW = 3
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0]   rot;
    logic [IDW-1:0] off;

    // rot[i] is the requester i positions after ptr; index arithmetic wraps mod N.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[IDW'(i) + ptr];
        end
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
        idx = off + ptr;
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner scheduler: grants one requester, holds while its request
// stays high, revokes it after MAX_HOLD cycles, then rotates priority.
module rr_grant_scheduler
    import rr_grant_scheduler_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int IDW      = DEF_IDW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid,
    output logic           preempt,
    output logic [1:0]     state_dbg
);

    localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    state_t         state_q;
    state_t         state_d;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_d;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_d;
    logic [N-1:0]   grant_d;
    logic [IDW-1:0] grant_id_d;
    logic           preempt_d;

    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic           owner_req;
    logic           timeout;

    rr_prio_encoder #(
        .N   (N),
        .IDW (IDW)
    ) u_prio_encoder (
        .req   (req),
        .ptr   (ptr),
        .found (win_found),
        .idx   (win_idx)
    );

    assign owner_req = req[grant_id];
    assign timeout   = (MAX_HOLD != 0) && (hold_cnt == HCW'(MAX_HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (win_found) state_d = ST_GRANT;
            ST_GRANT: if (!owner_req || timeout) state_d = ST_GAP;
            ST_GAP:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A release takes priority over a timeout, so a request dropping on the
    // final hold cycle never raises preempt.
    always_comb begin
        grant_d    = grant;
        grant_id_d = grant_id;
        ptr_d      = ptr;
        hold_d     = hold_cnt;
        preempt_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d    = {{(N-1){1'b0}}, 1'b1} << win_idx;
                    grant_id_d = win_idx;
                    hold_d     = HCW'(1);
                end
            end
            ST_GRANT: begin
                if (!owner_req || timeout) begin
                    grant_d   = '0;
                    ptr_d     = grant_id + 1'b1;
                    preempt_d = owner_req;
                end else if (hold_cnt != {HCW{1'b1}}) begin
                    hold_d = hold_cnt + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            grant    <= grant_d;
            grant_id <= grant_id_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
            preempt  <= preempt_d;
        end
    end

    assign grant_valid = |grant;
    assign state_dbg   = state_q;

endmodule
